// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory responder for a MIPS-style core.
// Accepts one load/store at a time through a valid/ready request port and
// returns a single response after a fixed, parameterised wait.
module mips_dmem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0]  LAT3    = 3'(LATENCY);
   localparam logic [31:0] DEPTH32 = 32'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [2:0]    cnt;
   logic [2:0]    cnt_nxt;
   logic          accept;
   logic          in_range;
   logic [AW-1:0] idx;
   logic [31:0]   mem [DEPTH];

   // Full 32-bit range compare; the index is only used when in range
   assign accept   = req_valid & req_ready;
   assign in_range = (req_addr < DEPTH32);
   assign idx      = req_addr[AW-1:0];

   // Next-state and wait-counter logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (LAT3 == 3'd0) begin
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = LAT3;
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_valid && rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   // State register with handshake flags decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 3'd0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= (state_nxt == S_IDLE);
         busy      <= (state_nxt != S_IDLE);
         rsp_valid <= (state_nxt == S_RESP);
      end
   end

   // Response payload captured at acceptance, cleared at retirement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_err   <= ~in_range;
         rsp_rdata <= (in_range && !req_we) ? mem[idx] : 32'd0;
      end else if (rsp_valid && rsp_ready) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end
   end

   // Storage array; deliberately not reset so stores survive a reset
   always_ff @(posedge clk) begin
      if (accept && in_range && req_we) begin
         mem[idx] <= req_wdata;
      end
   end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: a LATENCY=2 and a LATENCY=0 instance share
// one request stream; a transaction-level model predicts both every cycle.
module tb_mips_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int LAT_A = 2;
   localparam int LAT_B = 0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;

   logic        rdy_a, rv_a, re_a, bz_a;
   logic [31:0] rd_a;
   logic        rdy_b, rv_b, re_b, bz_b;
   logic [31:0] rd_b;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a),
      .rsp_err(re_a), .busy(bz_a)
   );

   mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b),
      .rsp_err(re_b), .busy(bz_b)
   );

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT_A : LAT_B;
   endfunction
   function automatic logic rdy_of(input int k);
      return (k == 0) ? rdy_a : rdy_b;
   endfunction
   function automatic logic rv_of(input int k);
      return (k == 0) ? rv_a : rv_b;
   endfunction
   function automatic logic bz_of(input int k);
      return (k == 0) ? bz_a : bz_b;
   endfunction
   function automatic logic re_of(input int k);
      return (k == 0) ? re_a : re_b;
   endfunction
   function automatic logic [31:0] rd_of(input int k);
      return (k == 0) ? rd_a : rd_b;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding request per instance, the
   // response is visible from LATENCY edges after the accepting edge.
   bit          m_pend  [2];
   int          m_acc   [2];
   logic [31:0] m_data  [2];
   bit          m_err   [2];
   bit          m_known [2];
   logic [31:0] m_mem   [2][DEPTH];
   bit          m_wr    [2][DEPTH];

   always @(posedge clk or negedge rst_n) begin
      if (clk) edge_n = edge_n + 1;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) m_pend[i] = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_pend[i]) begin
               if ((edge_n - 1) >= m_acc[i] + lat_of(i) && rsp_ready) m_pend[i] = 1'b0;
            end else if (req_valid) begin
               m_pend[i]  = 1'b1;
               m_acc[i]   = edge_n;
               m_known[i] = 1'b1;
               m_data[i]  = 32'd0;
               m_err[i]   = 1'b0;
               if (req_addr >= 32'(DEPTH)) begin
                  m_err[i] = 1'b1;
               end else if (req_we) begin
                  m_mem[i][req_addr[9:0]] = req_wdata;
                  m_wr[i][req_addr[9:0]]  = 1'b1;
               end else begin
                  m_data[i]  = m_mem[i][req_addr[9:0]];
                  m_known[i] = m_wr[i][req_addr[9:0]];
               end
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         bit ev;
         ev = m_pend[i] && (edge_n >= m_acc[i] + lat_of(i));
         chk("req_ready", i, 32'(rdy_of(i)), 32'(!m_pend[i]));
         chk("busy", i, 32'(bz_of(i)), 32'(m_pend[i]));
         chk("rsp_valid", i, 32'(rv_of(i)), 32'(ev));
         if (ev) begin
            if (m_known[i]) chk("rsp_rdata", i, rd_of(i), m_data[i]);
            chk("rsp_err", i, 32'(re_of(i)), 32'(m_err[i]));
         end else if (!m_pend[i]) begin
            chk("idle_rdata", i, rd_of(i), 32'd0);
            chk("idle_err", i, 32'(re_of(i)), 32'd0);
         end
      end
   end

   // Wait for instance k to be idle, present a request, return accepting edge
   task automatic issue(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output int acc_e);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rdy_of(k)) begin ok = 1'b1; break; end
      end
      chk("idle_timeout", k, 32'(ok), 32'd1);
      req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (!rdy_of(k)) begin ok = 1'b1; break; end
      end
      chk("accept_timeout", k, 32'(ok), 32'd1);
      acc_e = edge_n;
      req_valid = 1'b0;
   endtask

   task automatic collect(input int k, input int acc_e, output logic [31:0] rd,
                          output logic er, output int lat, output logic rdy_at);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (rv_of(k)) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("rsp_timeout", k, 32'(ok), 32'd1);
      lat = edge_n - acc_e + 1;
      rd = rd_of(k); er = re_of(k); rdy_at = rdy_of(k);
   endtask

   task automatic retire(input int k);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (!rv_of(k)) begin ok = 1'b1; break; end
      end
      chk("retire_timeout", k, 32'(ok), 32'd1);
   endtask

   task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat, output logic rdy_at);
      int acc_e;
      rsp_ready = 1'b1;
      issue(k, we, addr, wd, acc_e);
      collect(k, acc_e, rd, er, lat, rdy_at);
      retire(k);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        rdy_at;
      int          lat;
      int          acc_e;
      logic [31:0] sdat [8];
      int          acc_t [8];
      int          j;
      bit          prev_rdy;
      bit          seen;
      int          rr;

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_req_ready", k, 32'(rdy_of(k)), 32'd1);
         chk("rst_rsp_valid", k, 32'(rv_of(k)), 32'd0);
         chk("rst_rdata", k, rd_of(k), 32'd0);
         chk("rst_err", k, 32'(re_of(k)), 32'd0);
         chk("rst_busy", k, 32'(bz_of(k)), 32'd0);
      end
      rst_n = 1'b1;

      // Write-then-read at LATENCY=2
      txn(0, 1'b1, 32'd5, 32'hDEADBEEF, rd, er, lat, rdy_at);
      chk("wr5_latency", 0, 32'(lat), 32'd3);
      chk("wr5_rdata", 0, rd, 32'd0);
      txn(0, 1'b0, 32'd5, 32'd0, rd, er, lat, rdy_at);
      chk("rd5_latency", 0, 32'(lat), 32'd3);
      chk("rd5_rdata", 0, rd, 32'hDEADBEEF);
      chk("rd5_err", 0, 32'(er), 32'd0);

      // Zero latency instance
      txn(1, 1'b1, 32'd0, 32'h12345678, rd, er, lat, rdy_at);
      txn(1, 1'b0, 32'd0, 32'd0, rd, er, lat, rdy_at);
      chk("lat0_latency", 1, 32'(lat), 32'd1);
      chk("lat0_rdata", 1, rd, 32'h12345678);
      chk("lat0_req_ready", 1, 32'(rdy_at), 32'd0);

      // Backpressure with a competing store presented while held
      txn(0, 1'b1, 32'd7, 32'hA5A5A5A5, rd, er, lat, rdy_at);
      rsp_ready = 1'b0;
      issue(0, 1'b0, 32'd7, 32'd0, acc_e);
      collect(0, acc_e, rd, er, lat, rdy_at);
      req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'd0; req_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         chk("bp_valid", 0, 32'(rv_a), 32'd1);
         chk("bp_rdata", 0, rd_a, 32'hA5A5A5A5);
         chk("bp_busy", 0, 32'(bz_a), 32'd1);
         chk("bp_ready", 0, 32'(rdy_a), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      retire(0);
      txn(0, 1'b0, 32'd7, 32'd0, rd, er, lat, rdy_at);
      chk("bp_reload", 0, rd, 32'hA5A5A5A5);

      // Out-of-range accesses
      txn(0, 1'b1, 32'd1023, 32'hCAFEF00D, rd, er, lat, rdy_at);
      txn(0, 1'b1, 32'd0, 32'h0BADF00D, rd, er, lat, rdy_at);
      txn(0, 1'b1, 32'd1024, 32'h1, rd, er, lat, rdy_at);
      chk("oor_st_err", 0, 32'(er), 32'd1);
      chk("oor_st_rdata", 0, rd, 32'd0);
      txn(0, 1'b0, 32'd0, 32'd0, rd, er, lat, rdy_at);
      chk("oor_keep0", 0, rd, 32'h0BADF00D);
      txn(0, 1'b0, 32'd1023, 32'd0, rd, er, lat, rdy_at);
      chk("oor_keep1023", 0, rd, 32'hCAFEF00D);
      txn(0, 1'b0, 32'hFFFFFFFF, 32'd0, rd, er, lat, rdy_at);
      chk("oor_ld_err", 0, 32'(er), 32'd1);
      chk("oor_ld_rdata", 0, rd, 32'd0);

      // Reset while waiting after a committed store
      rsp_ready = 1'b1;
      issue(0, 1'b1, 32'd9, 32'h55, acc_e);
      rst_n = 1'b0;
      #1;
      chk("rstw_valid", 0, 32'(rv_a), 32'd0);
      chk("rstw_ready", 0, 32'(rdy_a), 32'd1);
      chk("rstw_busy", 0, 32'(bz_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req_we = 1'b0; req_addr = 32'd9; req_valid = 1'b1;
      @(negedge clk);
      chk("rstw_first_accept", 0, 32'(bz_a), 32'd1);
      req_valid = 1'b0;
      collect(0, edge_n, rd, er, lat, rdy_at);
      chk("rstw_rdata", 0, rd, 32'h55);
      chk("rstw_latency", 0, 32'(lat), 32'd3);
      retire(0);

      // Back-to-back alternating store/load with req_valid held high
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) sdat[k] = $urandom;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rdy_a) break;
      end
      req_we = 1'b1; req_addr = 32'd300; req_wdata = sdat[0]; req_valid = 1'b1;
      j = 0; prev_rdy = 1'b1; seen = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (rv_a && !seen) begin
            seen = 1'b1;
            if (((j - 1) % 2) == 1) chk("b2b_rdata", 0, rd_a, sdat[j - 2]);
         end
         if (prev_rdy && !rdy_a) begin
            acc_t[j] = edge_n;
            j++;
            seen = 1'b0;
            if (j < 8) begin
               req_we    = ((j % 2) == 0);
               req_addr  = 32'(300 + j - (j % 2));
               req_wdata = sdat[j];
            end else begin
               req_valid = 1'b0;
            end
         end
         prev_rdy = rdy_a;
         if (j == 8 && seen) break;
      end
      chk("b2b_count", 0, 32'(j), 32'd8);
      for (int k = 1; k < 8; k++) chk("b2b_spacing", 0, 32'(acc_t[k] - acc_t[k - 1]), 32'd4);
      retire(0);

      // Randomised traffic with occasional reset pulses
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if ($urandom_range(99) == 0) begin
            req_valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         req_valid = ($urandom_range(9) < 6);
         req_we    = $urandom_range(1) == 1;
         rr = $urandom_range(9);
         if (rr < 7)       req_addr = 32'($urandom_range(15));
         else if (rr == 7) req_addr = 32'(1020 + $urandom_range(7));
         else if (rr == 8) req_addr = $urandom;
         else              req_addr = 32'hFFFFFFFF;
         req_wdata = $urandom;
         rsp_ready = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_dmem_responder.md
MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the storage array.
REQ-002 The module SHALL have parameter LATENCY, default 2, legal range 0..7, meaning the wait cycles between request acceptance and response.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator has a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store (SW), 0 = load (LW).
REQ-008 req_addr  input  32  word address, the same word addressing as PC+1 stepping.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response is available.
REQ-011 rsp_ready  input  1  initiator accepts the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  address was out of range (req_addr >= DEPTH).
REQ-014 busy  output  1  a transaction is accepted and not yet retired.

Function
REQ-015 The module SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; req_ready is a registered state decode with no combinational path from any input.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 Request fields SHALL be sampled only at acceptance; later changes to the inputs SHALL have no effect on that transaction.
REQ-019 On acceptance of a store with req_addr < DEPTH, Mem[req_addr] SHALL be written with req_wdata at that same edge.
REQ-020 On acceptance of a load with req_addr < DEPTH, Mem[req_addr] SHALL be captured into the response register at that same edge.
REQ-021 On acceptance with req_addr >= DEPTH, memory SHALL be left unmodified, rsp_err SHALL be set to 1 for that response, and rsp_rdata SHALL be 0.
REQ-022 For a store, rsp_rdata SHALL be 0.
REQ-023 The full 32-bit address SHALL be compared against DEPTH, with no truncation or wrap-around.
REQ-024 On acceptance with LATENCY=0, the FSM SHALL go IDLE->RESP and rsp_valid SHALL be 1 in the cycle after acceptance.
REQ-025 On acceptance with LATENCY>0, the FSM SHALL go IDLE->WAIT and load a 3-bit down-counter with LATENCY.
REQ-026 In WAIT, the counter SHALL decrement once per cycle, and the FSM SHALL enter RESP on the edge where the counter equals 1.
REQ-027 rsp_valid SHALL first be 1 exactly LATENCY+1 cycles after the acceptance edge.
REQ-028 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
REQ-029 On the rising edge with rsp_valid=1 and rsp_ready=1, the FSM SHALL return to IDLE, and rsp_valid, rsp_rdata and rsp_err SHALL clear to 0.
REQ-030 The earliest next acceptance SHALL be one cycle after response retirement, giving a best-case throughput of one transaction per LATENCY+2 cycles.
REQ-031 rsp_ready asserted before rsp_valid SHALL be ignored.
REQ-032 req_valid seen outside IDLE SHALL be ignored and not queued.
REQ-033 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-034 At most one transaction SHALL be outstanding at any time.

Reset
REQ-035 While rst_n=0, the outputs SHALL be: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 Reset asserted in WAIT or RESP SHALL drop the pending response immediately.
REQ-038 A store already committed before a reset SHALL remain in memory.
REQ-039 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-040 Bench scenario, write-then-read: with LATENCY=2, store addr 5 data 0xDEADBEEF, then load addr 5 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid rising 3 cycles after each acceptance.
REQ-041 Bench scenario, zero latency: with LATENCY=0, load addr 0 after storing 0x12345678 -> rsp_valid=1 in the cycle after acceptance, and req_ready=0 in that same cycle.
REQ-042 Bench scenario, backpressure: rsp_ready held at 0 for 10 cycles during a load of addr 7 (value 0xA5A5A5A5) -> rsp_valid and rsp_rdata stay stable throughout, busy=1, and a second req_valid is ignored.
REQ-043 Bench scenario, out-of-range: store to addr 1024 with data 0x1 -> rsp_err=1 and rsp_rdata=0; then load addr 0 and addr 1023 -> contents unchanged; load addr 0xFFFFFFFF -> rsp_err=1.
REQ-044 Bench scenario, reset mid-operation: assert rst_n=0 while in WAIT after a store of 0x55 to addr 9 -> rsp_valid=0 and req_ready=1 immediately; a subsequent load of addr 9 -> 0x55.
REQ-045 Bench scenario, back-to-back: 8 alternating store/load requests with req_valid held high -> each accepted exactly once, with accept-to-accept spacing of LATENCY+2 cycles when rsp_ready=1.
